mic_level_meter: RTL and testbench

- Upstream feeder of the OLED volume visualiser. Converts the raw 12-bit microphone stream into a quantised loudness level of 0..9.
- Per window of WINDOW accepted samples: tracks the maximum sample, then quantises it with a sequential threshold-compare FSM.
- Applies peak-hold with one-step-per-window decay, then publishes audio_level with a one-cycle update strobe.
- The display stage reads audio_level directly to drive bar height and the level-bar stack.

---
 rtl/mic_level_meter_if.sv | 33 +++
 rtl/mic_level_meter.sv | 120 ++++++++++++
 tb/tb_mic_level_meter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mic_level_meter_if.sv
// Sample stream in, quantised loudness out.
//   sample_en   : one-cycle strobe; MIC_IN is accepted on this cycle
//   MIC_IN      : 12-bit unsigned microphone sample
//   audio_level : current loudness level, 0..MAX_LEVEL
//   level_valid : one-cycle pulse on the edge that audio_level updates
//   overrun     : one-cycle pulse when a window closes while the quantiser is busy
// master = the side that supplies samples, slave = the level meter.
interface mic_level_meter_if;
    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned LEVEL_W  = 5;

    logic                sample_en;
    logic [SAMPLE_W-1:0] MIC_IN;
    logic [LEVEL_W-1:0]  audio_level;
    logic                level_valid;
    logic                overrun;

    modport master (
        output sample_en,
        output MIC_IN,
        input  audio_level,
        input  level_valid,
        input  overrun
    );

    modport slave (
        input  sample_en,
        input  MIC_IN,
        output audio_level,
        output level_valid,
        output overrun
    );
endinterface

// File: rtl/mic_level_meter.sv
// Microphone loudness meter: per window of WINDOW accepted samples, take the
// peak sample, quantise it against FLOOR + k*STEP with one compare per cycle,
// then publish a 0..MAX_LEVEL level with optional one-step-per-window decay.
//   basys_clock : system clock, all state on the rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : slave side of mic_level_meter_if (samples in, level out)
module mic_level_meter #(
    parameter int unsigned WINDOW    = 2000,
    parameter logic [11:0] FLOOR     = 12'd2048,
    parameter logic [11:0] STEP      = 12'd200,
    parameter int unsigned MAX_LEVEL = 9,
    parameter bit          DECAY_EN  = 1'b1
) (
    input  logic              basys_clock,
    input  logic              rst_n,
    mic_level_meter_if.slave  bus
);

    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned THR_W    = 13;
    localparam int unsigned K_W      = 4;
    localparam int unsigned LEVEL_W  = 5;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WINDOW - 1);
    localparam logic [K_W-1:0]   K_LIMIT   = K_W'(MAX_LEVEL);
    localparam logic [THR_W-1:0] THR_FIRST = THR_W'(FLOOR) + THR_W'(STEP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        QUANT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    sample_cnt;
    logic [SAMPLE_W-1:0] run_max;
    logic [SAMPLE_W-1:0] peak_latched;
    logic [K_W-1:0]      k;
    logic [THR_W-1:0]    thr;

    logic [SAMPLE_W-1:0] win_max_c;
    logic                win_close_c;
    logic                reach_c;

    // Running peak including the sample arriving this cycle.
    assign win_max_c   = (bus.MIC_IN > run_max) ? bus.MIC_IN : run_max;
    assign win_close_c = bus.sample_en && (sample_cnt == CNT_LAST);
    // Peak equal to the threshold counts as reaching that level. thr never
    // exceeds 4095 + STEP, so 13 bits cannot wrap.
    assign reach_c     = (k < K_LIMIT) && ({1'b0, peak_latched} >= thr);

    // Window accumulation, quantiser FSM and level publish.
    always_ff @(posedge basys_clock or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            sample_cnt      <= '0;
            run_max         <= '0;
            peak_latched    <= '0;
            k               <= '0;
            thr             <= '0;
            bus.audio_level <= '0;
            bus.level_valid <= 1'b0;
            bus.overrun     <= 1'b0;
        end else begin
            bus.level_valid <= 1'b0;
            bus.overrun     <= 1'b0;

            // Accumulation runs regardless of the quantiser state.
            if (bus.sample_en) begin
                if (win_close_c) begin
                    sample_cnt <= '0;
                    run_max    <= '0;
                end else begin
                    sample_cnt <= sample_cnt + CNT_W'(1);
                    run_max    <= win_max_c;
                end
            end

            case (state)
                IDLE: begin
                    if (win_close_c) begin
                        peak_latched <= win_max_c;
                        k            <= '0;
                        thr          <= THR_FIRST;
                        state        <= QUANT;
                    end
                end
                QUANT: begin
                    // A window closing now is dropped; peak_latched is kept.
                    if (win_close_c) begin
                        bus.overrun <= 1'b1;
                    end
                    if (reach_c) begin
                        k   <= k + K_W'(1);
                        thr <= thr + THR_W'(STEP);
                    end else begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (win_close_c) begin
                        bus.overrun <= 1'b1;
                    end
                    if (!DECAY_EN || (LEVEL_W'(k) >= bus.audio_level)) begin
                        bus.audio_level <= LEVEL_W'(k);
                    end else begin
                        bus.audio_level <= bus.audio_level - LEVEL_W'(1);
                    end
                    bus.level_valid <= 1'b1;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mic_level_meter.sv
// Bench for mic_level_meter: three instances (decay, no decay, 15-level fine
// step) share one sample stream; a window-level model predicts every output.
module tb_mic_level_meter;

    localparam int W     = 16;
    localparam int FLR   = 2048;
    localparam int NDUT  = 3;
    localparam int NPUB  = 64;

    logic        basys_clock = 1'b0;
    logic        rst_n;
    logic        sample_en;
    logic [11:0] mic;

    always #5 basys_clock = ~basys_clock;

    mic_level_meter_if if_a ();
    mic_level_meter_if if_b ();
    mic_level_meter_if if_c ();

    assign if_a.sample_en = sample_en;
    assign if_b.sample_en = sample_en;
    assign if_c.sample_en = sample_en;
    assign if_a.MIC_IN    = mic;
    assign if_b.MIC_IN    = mic;
    assign if_c.MIC_IN    = mic;

    mic_level_meter #(.WINDOW(W), .DECAY_EN(1'b1)) dut_a (
        .basys_clock(basys_clock), .rst_n(rst_n), .bus(if_a.slave));
    mic_level_meter #(.WINDOW(W), .DECAY_EN(1'b0)) dut_b (
        .basys_clock(basys_clock), .rst_n(rst_n), .bus(if_b.slave));
    mic_level_meter #(.WINDOW(W), .STEP(12'd100), .MAX_LEVEL(15), .DECAY_EN(1'b1)) dut_c (
        .basys_clock(basys_clock), .rst_n(rst_n), .bus(if_c.slave));

    logic [4:0] act_lvl [NDUT];
    logic       act_vld [NDUT];
    logic       act_ovr [NDUT];

    assign act_lvl[0] = if_a.audio_level;
    assign act_lvl[1] = if_b.audio_level;
    assign act_lvl[2] = if_c.audio_level;
    assign act_vld[0] = if_a.level_valid;
    assign act_vld[1] = if_b.level_valid;
    assign act_vld[2] = if_c.level_valid;
    assign act_ovr[0] = if_a.overrun;
    assign act_ovr[1] = if_b.overrun;
    assign act_ovr[2] = if_c.overrun;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int cyc      = 0;

    // Model state, per instance.
    int m_cnt   [NDUT];
    int m_max   [NDUT];
    bit m_pend  [NDUT];
    int m_pub   [NDUT];
    int m_k     [NDUT];
    int m_close [NDUT];
    int m_lvl   [NDUT];
    bit e_vld   [NDUT];
    bit e_ovr   [NDUT];

    // Observed publishes and overruns, appended by the compare process.
    int pub_lvl [NDUT][NPUB];
    int pub_lat [NDUT][NPUB];
    int npub    [NDUT];
    int novr    [NDUT];
    int base_pub[NDUT];
    int base_ovr[NDUT];

    function automatic int step_of(int d);
        return (d == 2) ? 100 : 200;
    endfunction

    function automatic int max_of(int d);
        return (d == 2) ? 15 : 9;
    endfunction

    function automatic bit decay_of(int d);
        return (d != 1);
    endfunction

    // Highest level whose threshold the peak reaches.
    function automatic int quant(int peak, int d);
        int lvl = 0;
        for (int l = 1; l <= max_of(d); l++)
            if (peak >= FLR + l * step_of(d)) lvl = l;
        return lvl;
    endfunction

    task automatic chk(string name, int d, logic [31:0] act, int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            m_cnt[d] = 0; m_max[d] = 0; m_pend[d] = 0; m_pub[d] = 0;
            m_k[d] = 0; m_close[d] = 0; m_lvl[d] = 0; e_vld[d] = 0; e_ovr[d] = 0;
        end
    endtask

    // Advance the model across one rising edge with the inputs seen there.
    task automatic model_step(bit en, int val);
        for (int d = 0; d < NDUT; d++) begin
            bit busy = m_pend[d];
            e_vld[d] = 1'b0;
            e_ovr[d] = 1'b0;
            if (m_pend[d] && cyc == m_pub[d]) begin
                if (decay_of(d) && m_k[d] < m_lvl[d]) m_lvl[d] = m_lvl[d] - 1;
                else m_lvl[d] = m_k[d];
                e_vld[d]  = 1'b1;
                m_pend[d] = 1'b0;
            end
            if (en) begin
                int mx = (val > m_max[d]) ? val : m_max[d];
                if (m_cnt[d] == W - 1) begin
                    if (busy) begin
                        e_ovr[d] = 1'b1;
                    end else begin
                        m_pend[d]  = 1'b1;
                        m_k[d]     = quant(mx, d);
                        m_close[d] = cyc;
                        m_pub[d]   = cyc + m_k[d] + 2;
                    end
                    m_cnt[d] = 0;
                    m_max[d] = 0;
                end else begin
                    m_cnt[d]++;
                    m_max[d] = mx;
                end
            end
        end
        cyc++;
    endtask

    // Compare every output of every instance once per cycle.
    always @(negedge basys_clock) begin
        if (chk_en) begin
            for (int d = 0; d < NDUT; d++) begin
                chk("audio_level", d, 32'(act_lvl[d]), m_lvl[d]);
                chk("level_valid", d, 32'(act_vld[d]), int'(e_vld[d]));
                chk("overrun", d, 32'(act_ovr[d]), int'(e_ovr[d]));
                if (act_vld[d] === 1'b1 && npub[d] < NPUB) begin
                    pub_lvl[d][npub[d]] = int'(act_lvl[d]);
                    pub_lat[d][npub[d]] = cyc - 1 - m_close[d];
                    npub[d]++;
                end
                if (act_ovr[d] === 1'b1) novr[d]++;
            end
        end
    end

    task automatic drive(bit en, int val);
        sample_en = en;
        mic       = 12'(val);
        @(posedge basys_clock);
        if (rst_n) model_step(en, val);
        else cyc++;
        #2;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0);
    endtask

    task automatic window(int peak, int pos, int base, int gap);
        for (int i = 0; i < W; i++) begin
            drive(1'b1, (i == pos) ? peak : base);
            if (i != W - 1) for (int g = 0; g < gap; g++) drive(1'b0, 0);
        end
    endtask

    task automatic mark();
        for (int d = 0; d < NDUT; d++) begin
            base_pub[d] = npub[d];
            base_ovr[d] = novr[d];
        end
    endtask

    task automatic expect_count(string name, int d, int pubs, int ovrs);
        chk({name, "_npub"}, d, 32'(npub[d] - base_pub[d]), pubs);
        chk({name, "_novr"}, d, 32'(novr[d] - base_ovr[d]), ovrs);
    endtask

    // lat < 0 skips the latency check.
    task automatic expect_pub(string name, int d, int idx, int lvl, int lat);
        int i = base_pub[d] + idx;
        if (i >= npub[d]) begin
            chk({name, "_present"}, d, 32'(npub[d] - base_pub[d]), idx + 1);
        end else begin
            chk({name, "_lvl"}, d, 32'(pub_lvl[d][i]), lvl);
            if (lat >= 0) chk({name, "_lat"}, d, 32'(pub_lat[d][i]), lat);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            npub[d] = 0;
            novr[d] = 0;
        end
        rst_n     = 1'b0;
        sample_en = 1'b0;
        mic       = '0;
        model_reset();
        chk_en = 1'b1;
        idle(3);
        for (int d = 0; d < NDUT; d++) begin
            chk("rst_level", d, 32'(act_lvl[d]), 0);
            chk("rst_valid", d, 32'(act_vld[d]), 0);
        end
        rst_n = 1'b1;
        idle(2);

        // Model pins: threshold edges and clamp.
        chk("quant_2848", 0, 32'(quant(2848, 0)), 4);
        chk("quant_2847", 0, 32'(quant(2847, 0)), 3);
        chk("quant_4095", 0, 32'(quant(4095, 0)), 9);
        chk("quant_2247", 0, 32'(quant(2247, 0)), 0);
        chk("quant_4095_fine", 2, 32'(quant(4095, 2)), 15);

        // Silence: level 0 two cycles after the closing edge.
        mark();
        window(2048, 0, 2048, 0);
        idle(20);
        for (int d = 0; d < NDUT; d++) begin
            expect_count("silence", d, 1, 0);
            expect_pub("silence", d, 0, 0, 2);
        end

        // Full scale with gapped sample_en.
        mark();
        window(4095, 7, 2048, 1);
        idle(25);
        expect_pub("full", 0, 0, 9, 11);
        expect_pub("full", 1, 0, 9, 11);
        expect_pub("full", 2, 0, 15, 17);

        // Three silent windows: decay versus raw.
        mark();
        for (int w = 0; w < 3; w++) begin
            window(2048, 0, 2048, 0);
            idle(20);
        end
        expect_count("decay", 0, 3, 0);
        expect_pub("decay", 0, 0, 8, 2);
        expect_pub("decay", 0, 1, 7, 2);
        expect_pub("decay", 0, 2, 6, 2);
        expect_pub("raw", 1, 0, 0, 2);
        expect_pub("raw", 1, 1, 0, 2);
        expect_pub("raw", 1, 2, 0, 2);
        expect_pub("decay", 2, 2, 12, 2);

        // Threshold edge: exactly on FLOOR + 4*STEP, then one below.
        mark();
        window(2848, 3, 2048, 0);
        idle(20);
        window(2847, 9, 2000, 0);
        idle(20);
        expect_pub("thr_eq", 1, 0, 4, 6);
        expect_pub("thr_below", 1, 1, 3, 5);
        expect_pub("thr_decay", 0, 0, 5, 6);
        expect_pub("thr_decay", 0, 1, 4, 5);

        // Back-to-back windows: only the 15-level instance is still busy.
        mark();
        window(4095, 0, 2048, 0);
        window(2048, 0, 2048, 0);
        idle(25);
        expect_count("ovr", 2, 1, 1);
        expect_pub("ovr", 2, 0, 15, 17);
        expect_count("no_ovr", 0, 2, 0);
        expect_pub("no_ovr", 0, 0, 9, 11);
        expect_pub("no_ovr", 0, 1, 8, 2);
        expect_pub("no_ovr", 1, 1, 0, 2);

        // Reset three cycles into QUANT aborts the publish.
        mark();
        window(4095, 0, 2048, 0);
        idle(3);
        rst_n = 1'b0;
        model_reset();
        idle(3);
        rst_n = 1'b1;
        idle(15);
        for (int d = 0; d < NDUT; d++) begin
            expect_count("rst_abort", d, 0, 0);
            chk("rst_abort_level", d, 32'(act_lvl[d]), 0);
        end
        mark();
        window(2500, 5, 2048, 0);
        idle(25);
        expect_pub("after_rst", 0, 0, 2, 4);
        expect_pub("after_rst", 1, 0, 2, 4);
        expect_pub("after_rst", 2, 0, 4, 6);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
